// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, parity
// selection and serial line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } tx_state_e;

    localparam logic EVEN      = 1'b0;
    localparam logic ODD       = 1'b1;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bit-index counter width; kept at least 1 so a 1-bit frame still has a counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: XOR-reduction of the data word, inverted
// when odd parity is selected.
module uart_tx_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    import uart_pkg::*;

    assign par_bit = (par_typ == ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: one bit per CLK, frame = start, data LSB first,
// optional parity, stop. TX_OUT and BUSY are registered.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);
    import uart_pkg::*;

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt, cnt_inc;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_typ_q, par_bit;
    logic                  tx_nxt, busy_nxt, load;

    uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Outputs are computed for the state being entered, so the line level
    // and BUSY change on the same edge as the state register.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        tx_nxt    = IDLE_BIT;
        busy_nxt  = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    load      = 1'b1;
                    state_nxt = START;
                    tx_nxt    = START_BIT;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
                tx_nxt    = data_q[0];
                busy_nxt  = 1'b1;
            end
            DATA: begin
                busy_nxt = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (par_en_q) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_bit;
                    end else begin
                        state_nxt = STOP;
                        tx_nxt    = STOP_BIT;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    tx_nxt  = data_q[cnt_inc];
                end
            end
            PARITY: begin
                state_nxt = STOP;
                tx_nxt    = STOP_BIT;
                busy_nxt  = 1'b1;
            end
            STOP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            TX_OUT  <= IDLE_BIT;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            TX_OUT  <= tx_nxt;
            BUSY    <= busy_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (load) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

endmodule
